// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioner: button indices, repeat FSM states
// and the default timing at a 148.5 MHz pixel clock.
package button_conditioner_pkg;

  localparam int NUM_BTNS  = 4;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  localparam int TIMER_W = 27;

  localparam int DEF_DEBOUNCE_CYCLES = 1485000;
  localparam int DEF_REPEAT_DELAY    = 74250000;
  localparam int DEF_REPEAT_PERIOD   = 14850000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: synchroniser, debounce, press detect, auto-repeat FSM and
// the per-frame pending flag that collects move events.
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic frame_tick,
  output logic btn_level,
  output logic btn_press,
  output logic pending
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]    DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

  logic [1:0]         sync_q, sync_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               level_q, level_d;
  logic               press_q, press_d;
  rep_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pending_q, pending_d;
  logic               move_evt;

  // The counter only runs while the synchronised input disagrees with the level.
  always_comb begin
    sync_d   = {sync_q[0], btn_raw};
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  // A released button wins over any timer expiry in the same cycle.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    move_evt = 1'b0;
    if (!level_q) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timer_d = '0;
          if (press_q) begin
            state_d  = ST_HOLD;
            move_evt = 1'b1;
          end
        end
        ST_HOLD: begin
          if (timer_q == DELAY_LAST) begin
            state_d  = ST_REPEAT;
            timer_d  = '0;
            move_evt = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (timer_q == PERIOD_LAST) begin
            timer_d  = '0;
            move_evt = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
    pending_d = frame_tick ? move_evt : (pending_q | move_evt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;
  assign pending   = pending_q;

endmodule

// File: rtl/button_conditioner.sv
// Four debounced, auto-repeating buttons turned into frame-aligned move strobes;
// opposing directions requested in the same frame cancel each other.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw,
  input  logic                frame_tick,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] move_req
);

  logic [NUM_BTNS-1:0] pending;
  logic [NUM_BTNS-1:0] move_req_q, move_req_d;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[i]),
      .frame_tick(frame_tick),
      .btn_level (btn_level[i]),
      .btn_press (btn_press[i]),
      .pending   (pending[i])
    );
  end

  always_comb begin
    move_req_d = '0;
    if (frame_tick) begin
      move_req_d[BTN_UP]    = pending[BTN_UP]    & ~pending[BTN_DOWN];
      move_req_d[BTN_DOWN]  = pending[BTN_DOWN]  & ~pending[BTN_UP];
      move_req_d[BTN_LEFT]  = pending[BTN_LEFT]  & ~pending[BTN_RIGHT];
      move_req_d[BTN_RIGHT] = pending[BTN_RIGHT] & ~pending[BTN_LEFT];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_req_q <= '0;
    end else begin
      move_req_q <= move_req_d;
    end
  end

  assign move_req = move_req_q;

endmodule
